// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_pkg
// Description : Shared state encoding and default sizing for the sequential
//               restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

   // Default operand width and matching step-counter width (2**CNT_W > WIDTH)
   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 3;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : seq_restoring_divider_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration: shift the
//               partial remainder/quotient pair left, trial-subtract the
//               divisor, keep the difference only when no borrow occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_trial;
   logic           w_no_borrow;
   logic           w_unused_msb;

   // The partial remainder is always below the divisor, so its top bit is
   // zero on entry and is shifted out without loss.
   assign w_unused_msb = rem_i[WIDTH];

   // {R,Q} << 1: quotient MSB moves into the remainder LSB
   assign w_rem_sh = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};

   // Trial subtraction R' - {0,div} as R' + ~{0,div} + 1; carry-out means no borrow
   param_adder #(
      .WIDTH (WIDTH + 1)
   ) u_sub (
      .a_i    (w_rem_sh),
      .b_i    (~{1'b0, div_i}),
      .cin_i  (1'b1),
      .sum_o  (w_trial),
      .cout_o (w_no_borrow)
   );

   assign rem_o = w_no_borrow ? w_trial : w_rem_sh;
   assign quo_o = {quo_i[WIDTH-2:0], w_no_borrow};

endmodule : div_step
`default_nettype wire

// File: rtl/seq_restoring_divider_param_adder.sv
`default_nettype none
// ============================================================================
// Module      : param_adder
// Description : Parameterised ripple-carry adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module param_adder #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH:0] w_carry;

   assign w_carry[0] = cin_i;

   // One full-adder cell per bit, carry rippling from LSB to MSB
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ w_carry[gi];
      assign w_carry[gi+1] = (a_i[gi] & b_i[gi]) | (w_carry[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign cout_o = w_carry[WIDTH];

endmodule : param_adder
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, with a start/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_zero
);

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [WIDTH-1:0]   div_q,       div_d;
   logic [WIDTH:0]     rem_q,       rem_d;
   logic [WIDTH-1:0]   quo_q,       quo_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic [WIDTH-1:0]   quotient_q,  quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               div_zero_q,  div_zero_d;

   logic [WIDTH:0]     step_rem;
   logic [WIDTH-1:0]   step_quo;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Next-state logic: start acceptance, iteration and result capture
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;

      case (state_q)
         S_CALC: begin
            // Start requests are ignored here; operands stay latched
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               quotient_d  = step_quo;
               remainder_d = step_rem[WIDTH-1:0];
               div_zero_d  = 1'b0;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            // IDLE and DONE both accept a new start (back-to-back operation)
            state_d = S_IDLE;
            if (i_start) begin
               div_d      = i_divisor;
               rem_d      = '0;
               quo_d      = i_dividend;
               cnt_d      = CNT_W'(WIDTH);
               div_zero_d = 1'b0;
               if (i_divisor == '0) begin
                  // Divide-by-zero finishes immediately with saturated quotient
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = i_dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = S_CALC;
                  busy_d  = 1'b1;
               end
            end
         end
      endcase
   end

   // State and registered outputs; async reset aborts any operation in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_quotient  = quotient_q;
   assign o_remainder = remainder_q;
   assign o_div_zero  = div_zero_q;

endmodule : seq_restoring_divider
`default_nettype wire
